// File: rtl/arrow_scheduler.sv
// Arrow sprite slot allocator and lifetime sequencer.
// Hands spawn requests to free sprite slots, ages live arrows once per frame,
// and retires them on timeout (miss) or on a matching player hit in the window.
module arrow_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int LIFETIME  = 180,
  parameter int HIT_LO    = 168,
  parameter int HIT_HI    = 179
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   spawn_valid_in,
  input  logic [1:0]             spawn_direction_in,
  input  logic [2:0]             spawn_speed_in,
  output logic                   spawn_ready_out,
  input  logic                   hit_valid_in,
  input  logic [1:0]             hit_direction_in,
  output logic [NUM_SLOTS-1:0]   slot_valid_out,
  output logic [2*NUM_SLOTS-1:0] slot_direction_out,
  output logic [3*NUM_SLOTS-1:0] slot_speed_out,
  output logic                   hit_out,
  output logic                   whiff_out,
  output logic                   miss_out,
  output logic [15:0]            hit_count_out,
  output logic [15:0]            miss_count_out
);

  // DRAIN keeps valid low across a frame tick so the sprite reloads its start position
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_DRAIN  = 2'd2
  } slot_state_t;

  localparam logic [7:0] AGE_LAST = 8'(LIFETIME - 1);
  localparam logic [7:0] AGE_LO   = 8'(HIT_LO);
  localparam logic [7:0] AGE_HI   = 8'(HIT_HI);

  slot_state_t state_q [NUM_SLOTS];
  slot_state_t state_d [NUM_SLOTS];
  logic [7:0]  age_q   [NUM_SLOTS];
  logic [7:0]  age_d   [NUM_SLOTS];
  logic [1:0]  dir_q   [NUM_SLOTS];
  logic [1:0]  dir_d   [NUM_SLOTS];
  logic [2:0]  spd_q   [NUM_SLOTS];
  logic [2:0]  spd_d   [NUM_SLOTS];

  logic        hit_q, hit_d;
  logic        whiff_q, whiff_d;
  logic        miss_q, miss_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [16:0] miss_sum;
  logic [3:0]  miss_inc;

  logic        frame_tick;
  logic        spawn_found;
  int          spawn_idx;
  logic        hit_found;
  int          hit_idx;
  logic [7:0]  best_age;
  logic        spawn_fire;
  logic        hit_fire;

  assign frame_tick      = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign spawn_ready_out = spawn_found & ~rst;
  assign spawn_fire      = spawn_valid_in & spawn_ready_out;
  assign hit_fire        = hit_valid_in & hit_found;

  // Pick the lowest free slot for spawning and the oldest in-window matching arrow for a hit
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = 0;
    hit_found   = 1'b0;
    hit_idx     = 0;
    best_age    = 8'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        spawn_found = 1'b1;
        spawn_idx   = i;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((state_q[i] == SLOT_ACTIVE) && (dir_q[i] == hit_direction_in) &&
          (age_q[i] >= AGE_LO) && (age_q[i] <= AGE_HI) &&
          (!hit_found || (age_q[i] > best_age))) begin
        hit_found = 1'b1;
        hit_idx   = i;
        best_age  = age_q[i];
      end
    end
  end

  // Per-slot lifecycle: spawn capture, frame ageing, hit/timeout retirement, drain release
  always_comb begin
    miss_inc = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      dir_d[i]   = dir_q[i];
      spd_d[i]   = spd_q[i];
      case (state_q[i])
        SLOT_FREE: begin
          if (spawn_fire && (spawn_idx == i)) begin
            state_d[i] = SLOT_ACTIVE;
            age_d[i]   = 8'd0;
            dir_d[i]   = spawn_direction_in;
            spd_d[i]   = spawn_speed_in;
          end
        end
        SLOT_ACTIVE: begin
          if (hit_fire && (hit_idx == i)) begin
            state_d[i] = SLOT_DRAIN;
          end else if (frame_tick) begin
            if (age_q[i] == AGE_LAST) begin
              state_d[i] = SLOT_DRAIN;
              miss_inc   = miss_inc + 4'd1;
            end else begin
              age_d[i] = age_q[i] + 8'd1;
            end
          end
        end
        SLOT_DRAIN: begin
          if (frame_tick) begin
            state_d[i] = SLOT_FREE;
          end
        end
        default: state_d[i] = SLOT_FREE;
      endcase
    end
  end

  // Judgement pulses and saturating score counters
  always_comb begin
    hit_d      = hit_fire;
    whiff_d    = hit_valid_in & ~hit_found;
    miss_d     = (miss_inc != 4'd0);
    hit_cnt_d  = hit_cnt_q;
    if (hit_fire && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    miss_sum   = {1'b0, miss_cnt_q} + {13'd0, miss_inc};
    miss_cnt_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
        age_q[i]   <= 8'd0;
        dir_q[i]   <= 2'd0;
        spd_q[i]   <= 3'd0;
      end
      hit_q      <= 1'b0;
      whiff_q    <= 1'b0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
        dir_q[i]   <= dir_d[i];
        spd_q[i]   <= spd_d[i];
      end
      hit_q      <= hit_d;
      whiff_q    <= whiff_d;
      miss_q     <= miss_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Pack per-slot registers onto the sprite bank buses
  always_comb begin
    slot_valid_out     = '0;
    slot_direction_out = '0;
    slot_speed_out     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_valid_out[i]            = (state_q[i] == SLOT_ACTIVE);
      slot_direction_out[2*i +: 2] = dir_q[i];
      slot_speed_out[3*i +: 3]     = spd_q[i];
    end
  end

  assign hit_out        = hit_q;
  assign whiff_out      = whiff_q;
  assign miss_out       = miss_q;
  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;

endmodule

// File: doc/arrow_scheduler.md
Name: arrow_scheduler

Overview:
Slot allocator and lifetime sequencer for a bank of NUM_SLOTS arrow sprite instances. It accepts spawn requests (direction, speed), assigns each request to a free sprite slot, and holds that slot's valid/direction/speed steady while the arrow travels. It ages each slot once per video frame and retires the slot on timeout (miss) or on a matching player hit inside the judgement window. It sits between the chart/pattern source and the sprite bank, and its hit/miss outputs feed scoring.

Parameters:
NUM_SLOTS, 4, number of sprite instances managed (1..8)
LIFETIME, 180, frames an arrow stays active before a miss (720 px / 4 px per frame)
HIT_LO, 168, lowest age (frames) that counts as a hit, inclusive
HIT_HI, 179, highest age that counts as a hit, inclusive; HIT_LO <= HIT_HI < LIFETIME

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous, active-high reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current pixel row
spawn_valid_in  in  1  spawn request present
spawn_direction_in  in  2  requested arrow direction
spawn_speed_in  in  3  requested speed code (passed through)
spawn_ready_out  out  1  a slot is FREE; spawn accepted when valid&ready
hit_valid_in  in  1  one-cycle player input strobe
hit_direction_in  in  2  direction of player input
slot_valid_out  out  NUM_SLOTS  per-slot valid to sprite instances
slot_direction_out  out  2*NUM_SLOTS  per-slot direction, slot i at [2i+1:2i]
slot_speed_out  out  3*NUM_SLOTS  per-slot speed, slot i at [3i+2:3i]
hit_out  out  1  one-cycle pulse: judged hit
whiff_out  out  1  one-cycle pulse: hit input matched no slot
miss_out  out  1  one-cycle pulse: one or more arrows timed out
hit_count_out  out  16  saturating hit total
miss_count_out  out  16  saturating miss total

Behaviour:
- Reset (async, any time incl. mid-flight): all slots FREE, age 0; slot_valid_out=0, direction/speed=0; all pulses 0; counters 0. spawn_ready_out=0 while rst is high.
- frame_tick = (hcount_in==0 && vcount_in==0). It is high for exactly one clk per frame.
- Per-slot FSM: FREE -> ACTIVE -> DRAIN -> FREE. slot_valid_out[i]=1 only in ACTIVE.
- Spawn: spawn_ready_out = any slot FREE (combinational from registered state). On valid&ready, the lowest-index FREE slot captures direction/speed. On the next cycle it is ACTIVE with age 0. At most one spawn per cycle. Direction/speed are held constant while the slot is ACTIVE.
- Ageing: on frame_tick, each ACTIVE slot does age+1 (8-bit). If an ACTIVE slot has age==LIFETIME-1 at frame_tick, it goes to DRAIN instead of incrementing, and miss_out pulses the next cycle. miss_count adds the number of slots retired on that tick. A spawn accepted on the frame_tick cycle is not aged on that tick.
- Hit judgement on hit_valid_in: candidates are ACTIVE slots with direction==hit_direction_in and HIT_LO<=age<=HIT_HI. Select the largest age; ties go to the lowest index. The selected slot goes to DRAIN. hit_out pulses the next cycle and hit_count increments by 1. With no candidate, whiff_out pulses the next cycle and nothing else changes.
- DRAIN -> FREE on the next frame_tick after entry. This guarantees valid is low across at least one frame tick, so the sprite sees a fresh rising edge and reloads its start position.
- Simultaneous events:
  - hit and timeout on the same slot in the same cycle: hit wins, no miss is counted.
  - Hit, spawn and frame_tick in one cycle are each applied independently.
  - A slot leaving DRAIN is not spawnable until the following cycle.
- Counters saturate at 16'hFFFF; no wrap.
- Latency: spawn accept -> slot_valid_out high is 1 cycle. Hit strobe -> hit_out/whiff_out is 1 cycle. frame_tick -> miss_out is 1 cycle.

Test Plan:
- Reset, then spawn dir=2 speed=3 -> slot0 valid next cycle; slot_direction_out[1:0]=2, [2:0] speed=3; spawn_ready_out stays 1.
- Spawn NUM_SLOTS=4 requests back-to-back -> slots 0..3 valid; spawn_ready_out=0; a 5th request is held and not lost, and is accepted only after a slot returns FREE.
- Spawn, no input for 180 frame_ticks -> slot enters DRAIN on tick 180; miss_out one pulse; miss_count_out=1; slot FREE one tick later with valid low across that tick.
- Spawn dir=1, hit dir=1 at age 170 -> hit_out pulse, hit_count_out=1, slot valid low; a hit at age 100, or with dir=0, gives whiff_out only.
- Two dir=0 arrows at ages 175 and 172, hit dir=0 -> the age-175 slot retires; second hit retires the other; hit_count_out=2.
- Hit on the frame_tick where age==179 -> hit_out, no miss_out; assert rst mid-flight -> all outputs 0 immediately.
